tcdm_banks_pipe_wrap: RTL and testbench

Parametrised next-generation TCDM bank array for the cluster.
- Provides NbBanks independent single-port word-addressed SRAM banks behind OBI-style request/response ports.
- Adds a configurable read latency, an explicit response-valid signal, and ID return.
- Optionally adds read-modify-write (RMW) handling of partial writes for macros without byte enables.
- Sits between the cluster TCDM interconnect (logarithmic/HCI) and the physical memory macros.

---
 rtl/tcdm_banks_pipe_wrap.sv | 230 +++++++++++++++++++++++
 tb/tb_tcdm_banks_pipe_wrap.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_banks_pipe_wrap.sv
// TCDM bank array: NbBanks independent single-port SRAM banks behind OBI-style ports,
// with an RdLatency-deep response pipeline. Define TCDM_BANKS_RMW_EN for read-modify-write partial writes.
module tcdm_banks_pipe_wrap #(
    parameter int unsigned NbBanks   = 16,
    parameter int unsigned NbWords   = 256,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned RdLatency = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NbBanks-1:0]                 req_i,
    output logic [NbBanks-1:0]                 gnt_o,
    input  logic [NbBanks-1:0]                 wen_i,
    input  logic [NbBanks*32-1:0]              add_i,
    input  logic [NbBanks*DataWidth-1:0]       data_i,
    input  logic [NbBanks*(DataWidth/8)-1:0]   be_i,
    input  logic [NbBanks*IdWidth-1:0]         id_i,
    output logic [NbBanks*DataWidth-1:0]       r_data_o,
    output logic [NbBanks-1:0]                 r_valid_o,
    output logic [NbBanks*IdWidth-1:0]         r_id_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned AddrW   = $clog2(NbWords);
    localparam int unsigned OffW    = $clog2(BeWidth);

`ifdef TCDM_BANKS_RMW_EN
    typedef enum logic {
        IDLE,
        MERGE
    } rmw_state_e;
`endif

    for (genvar b = 0; b < NbBanks; b++) begin : g_bank
        logic [DataWidth-1:0] mem [NbWords];

        logic [AddrW-1:0]     in_idx;
        logic [DataWidth-1:0] in_data;
        logic [BeWidth-1:0]   in_be;
        logic [IdWidth-1:0]   in_id;
        logic                 gnt;
        logic                 accept;

        logic                 sram_en;
        logic                 sram_we;
        logic [AddrW-1:0]     sram_idx;
        logic [DataWidth-1:0] sram_wdata;
        logic [BeWidth-1:0]   sram_be;
        logic [DataWidth-1:0] rd_q;

        logic                 push_valid;
        logic                 push_read;
        logic [IdWidth-1:0]   push_id;

        logic                 s0_read;
        logic [DataWidth-1:0] s0_data;
        logic [DataWidth-1:0] out_data;
        logic [RdLatency-1:0] p_valid;
        logic [IdWidth-1:0]   p_id [RdLatency];
        logic                 unused_add;

        assign in_idx     = add_i[b*32+OffW +: AddrW];
        assign in_data    = data_i[b*DataWidth +: DataWidth];
        assign in_be      = be_i[b*BeWidth +: BeWidth];
        assign in_id      = id_i[b*IdWidth +: IdWidth];
        assign unused_add = ^add_i[b*32 +: 32];

        // Requests seen during reset are never accepted.
        assign accept  = req_i[b] & gnt & ~rst_i;
        assign gnt_o[b] = gnt;

`ifdef TCDM_BANKS_RMW_EN
        rmw_state_e           state_q;
        rmw_state_e           state_d;
        logic                 partial;
        logic                 latch_en;
        logic [AddrW-1:0]     lat_idx;
        logic [DataWidth-1:0] lat_data;
        logic [BeWidth-1:0]   lat_be;
        logic [IdWidth-1:0]   lat_id;
        logic [DataWidth-1:0] merged;

        assign partial = ~wen_i[b] & (in_be != '0) & (in_be != '1);
        assign gnt     = rst_i | (state_q == IDLE);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (latch_en) begin
                lat_idx  <= in_idx;
                lat_data <= in_data;
                lat_be   <= in_be;
                lat_id   <= in_id;
            end
        end

        // rd_q holds the old word captured when the partial write was accepted.
        always_comb begin
            merged = rd_q;
            for (int unsigned k = 0; k < BeWidth; k++) begin
                if (lat_be[k]) begin
                    merged[k*8 +: 8] = lat_data[k*8 +: 8];
                end
            end
        end

        always_comb begin
            state_d    = state_q;
            latch_en   = 1'b0;
            sram_en    = 1'b0;
            sram_we    = 1'b0;
            sram_idx   = in_idx;
            sram_wdata = in_data;
            sram_be    = '1;
            push_valid = 1'b0;
            push_read  = 1'b0;
            push_id    = in_id;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (partial) begin
                            sram_en  = 1'b1;
                            latch_en = 1'b1;
                            state_d  = MERGE;
                        end else begin
                            sram_en    = wen_i[b] | (in_be != '0);
                            sram_we    = ~wen_i[b];
                            push_valid = 1'b1;
                            push_read  = wen_i[b];
                        end
                    end
                end
                MERGE: begin
                    state_d = IDLE;
                    if (!rst_i) begin
                        sram_en    = 1'b1;
                        sram_we    = 1'b1;
                        sram_idx   = lat_idx;
                        sram_wdata = merged;
                        push_valid = 1'b1;
                        push_id    = lat_id;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`else
        assign gnt = 1'b1;

        always_comb begin
            sram_en    = accept & (wen_i[b] | (in_be != '0));
            sram_we    = ~wen_i[b];
            sram_idx   = in_idx;
            sram_wdata = in_data;
            sram_be    = in_be;
            push_valid = accept;
            push_read  = wen_i[b];
            push_id    = in_id;
        end
`endif

        // Memory contents are deliberately left out of reset.
        always_ff @(posedge clk_i) begin
            if (sram_en) begin
                if (sram_we) begin
                    for (int unsigned k = 0; k < BeWidth; k++) begin
                        if (sram_be[k]) begin
                            mem[sram_idx][k*8 +: 8] <= sram_wdata[k*8 +: 8];
                        end
                    end
                end else begin
                    rd_q <= mem[sram_idx];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                p_valid <= '0;
                s0_read <= 1'b0;
                for (int i = 0; i < RdLatency; i++) begin
                    p_id[i] <= '0;
                end
            end else begin
                p_valid[0] <= push_valid;
                s0_read    <= push_read & push_valid;
                p_id[0]    <= push_id;
                for (int i = 1; i < RdLatency; i++) begin
                    p_valid[i] <= p_valid[i-1];
                    p_id[i]    <= p_id[i-1];
                end
            end
        end

        assign s0_data = s0_read ? rd_q : '0;

        if (RdLatency == 1) begin : g_no_pipe
            assign out_data = s0_data;
        end else begin : g_pipe
            logic [DataWidth-1:0] dq [RdLatency-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < RdLatency - 1; i++) begin
                        dq[i] <= '0;
                    end
                end else begin
                    dq[0] <= s0_data;
                    for (int i = 1; i < RdLatency - 1; i++) begin
                        dq[i] <= dq[i-1];
                    end
                end
            end

            assign out_data = dq[RdLatency-2];
        end

        assign r_valid_o[b]                      = p_valid[RdLatency-1] & ~rst_i;
        assign r_id_o[b*IdWidth +: IdWidth]      = r_valid_o[b] ? p_id[RdLatency-1] : '0;
        assign r_data_o[b*DataWidth +: DataWidth] = r_valid_o[b] ? out_data : '0;
    end

endmodule

// File: tb/tb_tcdm_banks_pipe_wrap.sv
// Directed self-checking bench for tcdm_banks_pipe_wrap; adapts expected timing to TCDM_BANKS_RMW_EN.
module tb_tcdm_banks_pipe_wrap;

    localparam int NB  = 16;
    localparam int NW  = 256;
    localparam int DW  = 32;
    localparam int IW  = 1;
    localparam int LAT = 3;
`ifdef TCDM_BANKS_RMW_EN
    localparam int RMW = 1;
`else
    localparam int RMW = 0;
`endif

    logic              clk_i;
    logic              rst_i;
    logic [NB-1:0]     req_i;
    logic [NB-1:0]     gnt_o;
    logic [NB-1:0]     wen_i;
    logic [NB*32-1:0]  add_i;
    logic [NB*DW-1:0]  data_i;
    logic [NB*4-1:0]   be_i;
    logic [NB*IW-1:0]  id_i;
    logic [NB*DW-1:0]  r_data_o;
    logic [NB-1:0]     r_valid_o;
    logic [NB*IW-1:0]  r_id_o;

    int checks = 0;
    int errors = 0;

    tcdm_banks_pipe_wrap #(
        .NbBanks  (NB),
        .NbWords  (NW),
        .DataWidth(DW),
        .IdWidth  (IW),
        .RdLatency(LAT)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .wen_i    (wen_i),
        .add_i    (add_i),
        .data_i   (data_i),
        .be_i     (be_i),
        .id_i     (id_i),
        .r_data_o (r_data_o),
        .r_valid_o(r_valid_o),
        .r_id_o   (r_id_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic releaseAll();
        req_i = '0;
    endtask

    task automatic applyStimulus(input int b, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] be, input logic id);
        req_i[b]           = 1'b1;
        wen_i[b]           = wen;
        add_i[b*32 +: 32]  = addr;
        data_i[b*DW +: DW] = data;
        be_i[b*4 +: 4]     = be;
        id_i[b]            = id;
    endtask

    function automatic logic [31:0] rdata(input int b);
        return r_data_o[b*DW +: DW];
    endfunction

    // One isolated transaction: hold until granted, then expect exactly one response.
    task automatic doAccess(input string tag, input int b, input logic wen, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be, input logic id,
                            input logic [31:0] exp_data);
        int waited;
        int lat;
        waited = 0;
        applyStimulus(b, wen, addr, data, be, id);
        while (!gnt_o[b] && waited < 8) begin
            step();
            waited++;
        end
        checkOutput({tag, "_gnt"}, {31'd0, gnt_o[b]}, 32'd1);
        step();
        releaseAll();
        lat = LAT + ((RMW == 1 && !wen && be != 4'h0 && be != 4'hF) ? 1 : 0);
        for (int i = 1; i < lat; i++) begin
            checkOutput({tag, "_early"}, {31'd0, r_valid_o[b]}, 32'd0);
            step();
        end
        checkOutput({tag, "_valid"}, {31'd0, r_valid_o[b]}, 32'd1);
        checkOutput({tag, "_data"}, rdata(b), exp_data);
        checkOutput({tag, "_id"}, {31'd0, r_id_o[b]}, {31'd0, id});
        step();
        checkOutput({tag, "_once"}, {31'd0, r_valid_o[b]}, 32'd0);
    endtask

    initial begin
        rst_i  = 1'b1;
        req_i  = '0;
        wen_i  = '0;
        add_i  = '0;
        data_i = '0;
        be_i   = '0;
        id_i   = '0;

        // Reset behaviour, including a request that must be ignored.
        step();
        checkOutput("rst_gnt", {16'd0, gnt_o}, 32'h0000FFFF);
        checkOutput("rst_valid", {16'd0, r_valid_o}, 32'd0);
        applyStimulus(2, 1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
        step();
        checkOutput("rst_valid2", {16'd0, r_valid_o}, 32'd0);
        rst_i = 1'b0;
        releaseAll();
        for (int i = 0; i <= LAT + 1; i++) begin
            checkOutput("post_rst_quiet", {16'd0, r_valid_o}, 32'd0);
            step();
        end

        // Write then back-to-back read of the same word.
        applyStimulus(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        step();
        releaseAll();
        applyStimulus(0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
        step();
        releaseAll();
        for (int cyc = 2; cyc <= LAT + 2; cyc++) begin
            if (cyc == LAT) begin
                checkOutput("raw_wr_valid", {31'd0, r_valid_o[0]}, 32'd1);
                checkOutput("raw_wr_data", rdata(0), 32'd0);
                checkOutput("raw_wr_id", {31'd0, r_id_o[0]}, 32'd1);
            end else if (cyc == LAT + 1) begin
                checkOutput("raw_rd_valid", {31'd0, r_valid_o[0]}, 32'd1);
                checkOutput("raw_rd_data", rdata(0), 32'hDEADBEEF);
                checkOutput("raw_rd_id", {31'd0, r_id_o[0]}, 32'd0);
            end else begin
                checkOutput("raw_idle", {31'd0, r_valid_o[0]}, 32'd0);
            end
            step();
        end

        // Four back-to-back writes then four back-to-back reads on bank 1.
        for (int i = 0; i < 8 + LAT + 1; i++) begin
            int j;
            releaseAll();
            if (i < 4) begin
                applyStimulus(1, 1'b0, i * 4, i, 4'hF, i % 2);
            end else if (i < 8) begin
                applyStimulus(1, 1'b1, (i - 4) * 4, 32'h0, 4'h0, i % 2);
            end
            j = i - LAT;
            if (j >= 0 && j < 8) begin
                checkOutput("b2b_valid", {31'd0, r_valid_o[1]}, 32'd1);
                checkOutput("b2b_id", {31'd0, r_id_o[1]}, j % 2);
                checkOutput("b2b_data", rdata(1), (j < 4) ? 32'd0 : j - 4);
            end else begin
                checkOutput("b2b_idle", {31'd0, r_valid_o[1]}, 32'd0);
            end
            step();
        end
        releaseAll();

        // Partial write merges one byte; RMW stalls the following read by one cycle.
        doAccess("rmw_init", 2, 1'b0, 32'h14, 32'h11223344, 4'hF, 1'b0, 32'h0);
        applyStimulus(2, 1'b0, 32'h14, 32'hAABBCCDD, 4'h2, 1'b1);
        checkOutput("pw_gnt0", {31'd0, gnt_o[2]}, 32'd1);
        step();
        for (int c = 1; c <= 2 + RMW + LAT; c++) begin
            releaseAll();
            if (c <= 1 + RMW) begin
                applyStimulus(2, 1'b1, 32'h14, 32'h0, 4'h0, 1'b0);
            end
            checkOutput("pw_gnt", {31'd0, gnt_o[2]}, (RMW == 1 && c == 1) ? 32'd0 : 32'd1);
            if (c == LAT + RMW) begin
                checkOutput("pw_wr_valid", {31'd0, r_valid_o[2]}, 32'd1);
                checkOutput("pw_wr_data", rdata(2), 32'd0);
                checkOutput("pw_wr_id", {31'd0, r_id_o[2]}, 32'd1);
            end else if (c == 1 + RMW + LAT) begin
                checkOutput("pw_rd_valid", {31'd0, r_valid_o[2]}, 32'd1);
                checkOutput("pw_rd_data", rdata(2), 32'h1122CC44);
                checkOutput("pw_rd_id", {31'd0, r_id_o[2]}, 32'd0);
            end else begin
                checkOutput("pw_idle", {31'd0, r_valid_o[2]}, 32'd0);
            end
            step();
        end
        releaseAll();
        doAccess("pw_reread", 2, 1'b1, 32'h14, 32'h0, 4'h0, 1'b1, 32'h1122CC44);

        // Banks 0 and 7 answer independently in the same cycle.
        doAccess("ind_w0", 0, 1'b0, 32'h24, 32'h0000AAAA, 4'hF, 1'b0, 32'h0);
        doAccess("ind_w7", 7, 1'b0, 32'h24, 32'h77770007, 4'hF, 1'b1, 32'h0);
        applyStimulus(0, 1'b1, 32'h24, 32'h0, 4'h0, 1'b1);
        applyStimulus(7, 1'b1, 32'h24, 32'h0, 4'h0, 1'b0);
        step();
        releaseAll();
        for (int c = 1; c <= LAT + 1; c++) begin
            checkOutput("ind_v0", {31'd0, r_valid_o[0]}, (c == LAT) ? 32'd1 : 32'd0);
            checkOutput("ind_v7", {31'd0, r_valid_o[7]}, (c == LAT) ? 32'd1 : 32'd0);
            if (c == LAT) begin
                checkOutput("ind_d0", rdata(0), 32'h0000AAAA);
                checkOutput("ind_d7", rdata(7), 32'h77770007);
                checkOutput("ind_id0", {31'd0, r_id_o[0]}, 32'd1);
                checkOutput("ind_id7", {31'd0, r_id_o[7]}, 32'd0);
            end
            step();
        end
        doAccess("be0_wr", 7, 1'b0, 32'h24, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0);
        doAccess("be0_rd", 7, 1'b1, 32'h24, 32'h0, 4'h0, 1'b0, 32'h77770007);

        // Reset while a read is in flight; memory survives, reset-time requests are ignored.
        doAccess("mr_w3", 3, 1'b0, 32'h8, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
        doAccess("mr_w4", 4, 1'b0, 32'h4, 32'h12345678, 4'hF, 1'b0, 32'h0);
        applyStimulus(3, 1'b1, 32'h8, 32'h0, 4'h0, 1'b1);
        step();
        releaseAll();
        rst_i = 1'b1;
        applyStimulus(4, 1'b0, 32'h4, 32'h0, 4'hF, 1'b1);
        for (int c = 0; c < 2; c++) begin
            checkOutput("mr_valid", {16'd0, r_valid_o}, 32'd0);
            checkOutput("mr_data", {31'd0, r_data_o == '0}, 32'd1);
            checkOutput("mr_id", {16'd0, r_id_o}, 32'd0);
            checkOutput("mr_gnt", {16'd0, gnt_o}, 32'h0000FFFF);
            step();
        end
        rst_i = 1'b0;
        releaseAll();
        for (int c = 0; c <= LAT + 1; c++) begin
            checkOutput("mr_dropped", {16'd0, r_valid_o}, 32'd0);
            step();
        end
        doAccess("mr_r3", 3, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
        doAccess("mr_r4", 4, 1'b1, 32'h4, 32'h0, 4'h0, 1'b1, 32'h12345678);

        // Upper and lower address bits are ignored.
        doAccess("addr_wr", 5, 1'b0, 32'hFFFFF00C, 32'h0BADCAFE, 4'hF, 1'b0, 32'h0);
        doAccess("addr_rd", 5, 1'b1, 32'h0000000C, 32'h0, 4'h0, 1'b1, 32'h0BADCAFE);
        doAccess("addr_alias", 5, 1'b1, 32'h0000040D, 32'h0, 4'h0, 1'b0, 32'h0BADCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
